ram_arbiter: RTL and testbench

- Two-requester access controller for the 32 x 32-bit single-port `ram` (ports clk, ena, wena, addr, data_in, data_out).
- Serialises read/write requests from two masters onto the one RAM port, using round-robin arbitration and a req/ack handshake.
- Sits between the RAM and two client blocks (e.g. a CPU datapath and a debug/loader port); it is the only driver of the RAM control pins.

---
 rtl/ram_arbiter_pkg.sv | 12 +
 rtl/ram_arbiter_rr_pick2.sv | 20 ++
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared FSM encoding, requester IDs and default widths for ram_arbiter.
package ram_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: two-way winner select; round-robin, or fixed priority to requester 0
// when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic valid_o,
  output logic winner_o
);
  assign valid_o = req0_i || req1_i;
`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
  assign winner_o = req0_i ? REQ0 : REQ1;
`else
  assign winner_o = (req0_i && req1_i) ? ~last_gnt_i : (req1_i ? REQ1 : REQ0);
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two req/ack masters onto one single-port RAM (IDLE/ACCESS/RESP).
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ram_arbiter #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  import ram_arb_pkg::*;
  state_e state_q;
  logic last_gnt_q, gnt_q, ack0_q, ack1_q, busy_q, ena_q, wena_q, valid, win;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  rr_pick2 u_pick (
    .req0_i    (req0),
    .req1_i    (req1),
    .last_gnt_i(last_gnt_q),
    .valid_o   (valid),
    .winner_o  (win)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= REQ1;
      gnt_q      <= REQ0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      ena_q      <= 1'b0;
      wena_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (valid) begin
          state_q    <= ST_ACCESS;
          busy_q     <= 1'b1;
          ena_q      <= 1'b1;
          wena_q     <= win ? we1 : we0;
          addr_q     <= win ? addr1 : addr0;
          wdata_q    <= win ? wdata1 : wdata0;
          gnt_q      <= win;
          last_gnt_q <= win;
        end
        ST_ACCESS: begin
          // RAM read data is combinational, so it is captured on the same edge that closes ACCESS
          state_q <= ST_RESP;
          ena_q   <= 1'b0;
          wena_q  <= 1'b0;
          ack0_q  <= gnt_q == REQ0;
          ack1_q  <= gnt_q == REQ1;
          if (!wena_q && gnt_q == REQ0) rdata0_q <= ram_rdata;
          if (!wena_q && gnt_q == REQ1) rdata1_q <= ram_rdata;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign ram_ena   = ena_q;
  assign ram_wena  = wena_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed steps with a RAM model and an ack-order/read-data scoreboard.
module tb_ram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, busy, ram_ena, ram_wena;
  logic [31:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [4:0] ram_addr;
  logic [31:0] mem [32];
  logic pre_en = 0;
  logic [4:0] pre_addr = 0;
  logic [31:0] pre_data = 0;
  int total = 0, passed = 0;
  typedef struct {logic id; logic rd; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t e_mon;

  ram_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
    else if (pre_en) mem[pre_addr] <= pre_data;
  assign ram_rdata = (ram_ena && !ram_wena) ? mem[ram_addr] : 'z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic id, input logic rd, input logic [31:0] d);
    sb.push_back('{id, rd, d});
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk) #1;
    pre_en = 1; pre_addr = a; pre_data = d;
    @(posedge clk) #1;
    pre_en = 0;
  endtask

  // Raises the selected requests and drops each one on the edge after its ack is seen.
  task automatic serve(input logic u0, input logic u1, output int lat0);
    logic p0, p1, a0, a1;
    int n;
    p0 = u0; p1 = u1; n = 0; lat0 = 0;
    @(posedge clk) #1;
    req0 = u0; req1 = u1;
    while ((p0 || p1) && n < 30) begin
      @(negedge clk);
      n++;
      a0 = ack0; a1 = ack1;
      if (a0 && lat0 == 0) lat0 = n;
      @(posedge clk) #1;
      if (a0) begin req0 = 0; p0 = 0; end
      if (a1) begin req1 = 0; p1 = 0; end
    end
    chk("serve_done", {30'b0, p0, p1}, 0);
  endtask

  always @(negedge clk)
    if (!rst && (ack0 || ack1)) begin
      if (sb.size() == 0) chk("unexpected_ack", {30'b0, ack1, ack0}, 0);
      else begin
        e_mon = sb.pop_front();
        chk("ack_id", {30'b0, ack1, ack0}, e_mon.id ? 32'd2 : 32'd1);
        if (e_mon.rd) chk(e_mon.id ? "rdata1" : "rdata0", e_mon.id ? rdata1 : rdata0, e_mon.data);
      end
    end

  initial begin
    int lat, ena_cnt;
    preload(5'd2, 32'h87654321);
    preload(5'd3, 32'hABCDEF01);
    preload(5'd5, 32'h55AA55AA);
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("rst_ack0", {31'b0, ack0}, 0);
    chk("rst_ack1", {31'b0, ack1}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ram_ena", {31'b0, ram_ena}, 0);
    chk("rst_ram_wena", {31'b0, ram_wena}, 0);
    chk("rst_ram_addr", {27'b0, ram_addr}, 0);
    chk("rst_ram_wdata", ram_wdata, 0);

    // first tie after reset goes to requester 0
    we0 = 1; addr0 = 5'd1; wdata0 = 32'h12345678;
    we1 = 1; addr1 = 5'd6; wdata1 = 32'h0BADF00D;
    push(0, 0, 0); push(1, 0, 0);
    serve(1, 1, lat);

`ifndef RAM_ARB_FIXED_PRIO_EN
    // both held continuously: grants alternate, one RAM access every 3 cycles
    we0 = 0; addr0 = 5'd2; we1 = 0; addr1 = 5'd3;
    push(0, 1, 32'h87654321); push(1, 1, 32'hABCDEF01);
    push(0, 1, 32'h87654321); push(1, 1, 32'hABCDEF01);
    req0 = 1; req1 = 1; ena_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ena_cnt += int'(ram_ena);
    end
    @(posedge clk) #1;
    req0 = 0; req1 = 0;
    chk("ena_duty", ena_cnt, 4);
    chk("sb_drain_rr", sb.size(), 0);
`endif

    we0 = 0; addr0 = 5'd1;
    push(0, 1, 32'h12345678);
    serve(1, 0, lat);
    chk("read_latency", lat, 3);
`ifdef RAM_ARB_FIXED_PRIO_EN
    chk("rdata1_idle", rdata1, 0);
`else
    chk("rdata1_hold", rdata1, 32'hABCDEF01);

    // last_gnt=0: requester 1's write lands before requester 0's read
    we1 = 1; addr1 = 5'd4; wdata1 = 32'h11223344;
    we0 = 0; addr0 = 5'd4;
    push(1, 0, 0); push(0, 1, 32'h11223344);
    serve(1, 1, lat);
`endif

    // reset cuts a write in its ACCESS cycle
    we0 = 1; addr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    @(posedge clk) #1;
    req0 = 1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_ena_before", {31'b0, ram_ena}, 1);
    #1 rst = 1;
    #1;
    chk("abort_ena_after", {31'b0, ram_ena}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ack0", {31'b0, ack0}, 0);
    req0 = 0;
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("abort_no_ack", {30'b0, ack1, ack0}, 0);
    we0 = 0;
    push(0, 1, 32'h55AA55AA);
    serve(1, 0, lat);

`ifdef RAM_ARB_FIXED_PRIO_EN
    we0 = 0; addr0 = 5'd2; we1 = 0; addr1 = 5'd3;
    push(0, 1, 32'h87654321); push(0, 1, 32'h87654321); push(0, 1, 32'h87654321);
    @(posedge clk) #1;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 9; i++) @(negedge clk);
    @(posedge clk) #1;
    req0 = 0; req1 = 0;
    chk("fixed_drain", sb.size(), 0);
    push(1, 1, 32'hABCDEF01);
    serve(0, 1, lat);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
